des_dec_key_sched: RTL and testbench
====================================

DES_DEC_KEY_SCHED -- requirements
Module: des_dec_key_sched

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 start  input  1  Request a new schedule; sampled only in IDLE.
REQ-005 key_in  input  64  DES key; key_in[63] is DES bit 1; parity bits (DES 8,16,...,64) are ignored.
REQ-006 sk_ready  input  1  Consumer accepts subkey this cycle.
REQ-007 sk_valid  output  1  subkey and round_idx are valid.
REQ-008 subkey  output  48  PC-2 of the current C,D; subkey[47] is PC-2 output bit 1.
REQ-009 round_idx  output  4  Round number minus 1 (15 = K16, 0 = K1).
REQ-010 busy  output  1  High in states GEN and LAST.
REQ-011 done  output  1  One-cycle pulse after the final subkey transfer.

Function
REQ-012 The FSM SHALL have states IDLE, GEN and LAST, and SHALL encode no other reachable states.
REQ-013 In IDLE, when start=1, the block SHALL load C,D = PC-1(key_in), set round_idx=15 and go to GEN on that clock edge.
REQ-014 start SHALL be ignored while busy=1, and key_in SHALL NOT be resampled during a schedule.
REQ-015 A transfer SHALL occur on any edge where sk_valid=1 and sk_ready=1.
REQ-016 sk_valid SHALL equal busy.
REQ-017 subkey SHALL be a combinational PC-2 of the registered C,D, and SHALL be stable while sk_valid=1 and sk_ready=0.
REQ-018 First-valid latency SHALL be 1 cycle: start sampled at edge N gives sk_valid=1 with K16 in the cycle after edge N.
REQ-019 The first subkey SHALL be K16 = PC-2(C0,D0), because the total left rotation over 16 rounds is 28.
REQ-020 On a transfer of K_i with i in 16..2, C and D SHALL each rotate RIGHT by S[i], and round_idx SHALL decrement by 1.
REQ-021 The shift table SHALL be S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 The block SHALL go to LAST when round_idx reaches 0, and SHALL stay in LAST presenting K1 until transferred.
REQ-023 The transfer of K1 SHALL return the FSM to IDLE and assert done for exactly the next cycle.
REQ-024 Throughput SHALL be one subkey per cycle while sk_ready is held at 1, giving 16 subkeys in 16 consecutive cycles.
REQ-025 If start=1 in the same cycle that done=1 (FSM in IDLE), the block SHALL begin a new schedule normally.
REQ-026 sk_ready asserted while sk_valid=0 SHALL have no effect.

Reset
REQ-027 When rst=1, the block SHALL set state=IDLE, C=D=0, round_idx=0, sk_valid=0, busy=0 and done=0 immediately, without waiting for a clock edge.
REQ-028 While rst=1, subkey SHALL equal PC-2(0,0), i.e. 48'h0.
REQ-029 Reset asserted mid-schedule SHALL abort the schedule; after reset the block SHALL require a new start and SHALL NOT pulse done.

Configuration
REQ-030 When macro DES_KS_ENC_DIR_EN is defined, the block SHALL add input mode (1 bit).
- mode=1: encrypt order, using the mode value sampled with start.
- In encrypt order, the first subkey SHALL be PC-2 of C0,D0 rotated left by S[1] (that is, K1), with round_idx=0.
- Each transfer of K_i SHALL then rotate left by S[i+1] and increment round_idx.
- In encrypt order, LAST SHALL be reached at round_idx=15.
REQ-031 With DES_KS_ENC_DIR_EN defined and mode=0, behaviour SHALL be identical to the decrypt-only build.
REQ-032 When DES_KS_ENC_DIR_EN is undefined, the block SHALL have no mode port and SHALL produce decrypt order only.

Verification
REQ-033 key_in=64'h133457799BBCDFF1, start pulse, sk_ready=1 -> cycle 1: subkey=48'hCB3D8B0E17F5, round_idx=15; cycle 2: subkey=48'hBF918D3D3F0A, round_idx=14.
REQ-034 Same key, sk_ready=1 continuously -> 16th subkey=48'h1B02EFFC7072, round_idx=0; done=1 on the next cycle only; busy=0.
REQ-035 Same key, sk_ready toggled 0/1 pseudo-randomly -> subkey holds steady while stalled; the 16 delivered values match a golden model exactly; no value is skipped or repeated.
REQ-036 rst asserted after the 5th transfer -> sk_valid=0 and busy=0 immediately, no done pulse; a fresh start then yields 48'hCB3D8B0E17F5 first.
REQ-037 start pulsed while busy with key_in changed to 64'h0 -> the current schedule is unaffected and completes with 48'h1B02EFFC7072.
REQ-038 DES_KS_ENC_DIR_EN defined, mode=1, same key -> first subkey=48'h1B02EFFC7072 (round_idx=0), last subkey=48'hCB3D8B0E17F5 (round_idx=15).

Source files
------------

// File: rtl/des_dec_key_sched.sv
// DES key schedule producing subkeys K16..K1 (decrypt order) over a valid/ready handshake.
// Optional macro DES_KS_ENC_DIR_EN adds a mode input selecting encrypt order (K1..K16).
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
`ifdef DES_KS_ENC_DIR_EN
  input  logic        mode,
`endif
  input  logic        sk_ready,
  output logic        sk_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 2 * HALF_W;
  localparam int unsigned SK_W   = 48;

  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2 [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Bit r is set when S[r+1] == 2 (otherwise the shift is 1).
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  typedef enum logic [1:0] {IDLE, GEN, LAST} state_t;

  state_t              state, state_n;
  logic [HALF_W-1:0]   c_q, d_q, c_n, d_n;
  logic [3:0]          round_q, round_n;
  logic                done_q, done_n;
  logic [CD_W-1:0]     cd0;
  logic                xfer;
`ifdef DES_KS_ENC_DIR_EN
  logic                enc_q, enc_n;
`endif

  // DES bit b lives at vector index (width - b); bit 1 is the MSB.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int j = 0; j < CD_W; j++)
      r[6'(CD_W - 1 - j)] = k[6'(KEY_W - PC1[j])];
    return r;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] r;
    r = '0;
    for (int j = 0; j < SK_W; j++)
      r[6'(SK_W - 1 - j)] = cd[6'(CD_W - PC2[j])];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  assign busy      = (state == GEN) || (state == LAST);
  assign sk_valid  = busy;
  assign round_idx = round_q;
  assign done      = done_q;
  assign subkey    = pc2({c_q, d_q});
  assign cd0       = pc1(key_in);
  assign xfer      = sk_valid && sk_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef DES_KS_ENC_DIR_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      c_q     <= c_n;
      d_q     <= d_n;
      round_q <= round_n;
      done_q  <= done_n;
`ifdef DES_KS_ENC_DIR_EN
      enc_q   <= enc_n;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    c_n     = c_q;
    d_n     = d_q;
    round_n = round_q;
    done_n  = 1'b0;
`ifdef DES_KS_ENC_DIR_EN
    enc_n   = enc_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          c_n     = cd0[CD_W-1:HALF_W];
          d_n     = cd0[HALF_W-1:0];
          round_n = 4'd15;
          state_n = GEN;
`ifdef DES_KS_ENC_DIR_EN
          enc_n = mode;
          if (mode) begin
            c_n     = rotl(cd0[CD_W-1:HALF_W], SHIFT2[0]);
            d_n     = rotl(cd0[HALF_W-1:0], SHIFT2[0]);
            round_n = 4'd0;
          end
`endif
        end
      end
      GEN: begin
        if (xfer) begin
`ifdef DES_KS_ENC_DIR_EN
          if (enc_q) begin
            c_n     = rotl(c_q, SHIFT2[round_q + 4'd1]);
            d_n     = rotl(d_q, SHIFT2[round_q + 4'd1]);
            round_n = round_q + 4'd1;
            if (round_q == 4'd14) state_n = LAST;
          end else begin
            c_n     = rotr(c_q, SHIFT2[round_q]);
            d_n     = rotr(d_q, SHIFT2[round_q]);
            round_n = round_q - 4'd1;
            if (round_q == 4'd1) state_n = LAST;
          end
`else
          c_n     = rotr(c_q, SHIFT2[round_q]);
          d_n     = rotr(d_q, SHIFT2[round_q]);
          round_n = round_q - 4'd1;
          if (round_q == 4'd1) state_n = LAST;
`endif
        end
      end
      LAST: begin
        if (xfer) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Scoreboard bench for des_dec_key_sched using the classic 133457799BBCDFF1 key schedule.
module tb_des_dec_key_sched;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  // KD[i] is K(i+1) for the key above.
  localparam logic [47:0] KD [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  ri;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, sk_ready;
  logic [63:0] key_in;
  logic        sk_valid, busy, done;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
`ifdef DES_KS_ENC_DIR_EN
  logic        mode;
`endif

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_done = 1'b0;
  logic        hold_v = 1'b0;
  logic [47:0] hold_sk;
  logic [31:0] stall_pat = 32'hB274_CA39;
  int          cyc;

  des_dec_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
`ifdef DES_KS_ENC_DIR_EN
    .mode     (mode),
`endif
    .sk_ready (sk_ready),
    .sk_valid (sk_valid),
    .subkey   (subkey),
    .round_idx(round_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, tracks stall stability and done.
  always @(negedge clk) begin
    if (rst) begin
      hold_v   = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || done) check("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (hold_v && sk_valid) check("stall_hold", 64'(subkey), 64'(hold_sk));
      hold_v = 1'b0;
      if (sk_valid || busy) check("valid_eq_busy", 64'(sk_valid), 64'(busy));
      if (sk_valid) begin
        if (sk_ready) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_transfer: got subkey %h expected no transfer", subkey);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("subkey", 64'(subkey), 64'(e.sk));
            check("round_idx", 64'(round_idx), 64'(e.ri));
            if (e.last) exp_done = 1'b1;
          end
        end else begin
          hold_v  = 1'b1;
          hold_sk = subkey;
        end
      end
    end
  end

  task automatic start_sched(input logic [63:0] k, input bit enc);
    int rr;
    for (int r = 0; r < 16; r++) begin
      rr = enc ? r : 15 - r;
      q.push_back('{sk: KD[rr], ri: 4'(rr), last: (enc ? (rr == 15) : (rr == 0))});
    end
    key_in = k;
    start  = 1'b1;
`ifdef DES_KS_ENC_DIR_EN
    mode = enc;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("first_valid", 64'(sk_valid), 64'd1);
    check("first_round", 64'(round_idx), enc ? 64'd0 : 64'd15);
  endtask

  task automatic drain(input bit stall, output int cycles);
    int budget;
    int i;
    budget = 200;
    cycles = 0;
    i      = 0;
    while (q.size() > 0 && budget > 0) begin
      sk_ready = stall ? stall_pat[5'(i)] : 1'b1;
      i++;
      @(posedge clk); #1;
      cycles++;
      budget--;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; sk_ready = 1'b0; key_in = '0;
`ifdef DES_KS_ENC_DIR_EN
    mode = 1'b0;
`endif
    #1;
    check("rst_valid", 64'(sk_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_round", 64'(round_idx), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // sk_ready while idle does nothing
    sk_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ready_valid", 64'(sk_valid), 64'd0);
    end

    // Continuous throughput, then back-to-back start in the done cycle
    start_sched(KEY, 1'b0);
    drain(1'b0, cyc);
    check("throughput_cycles", 64'(cyc), 64'd16);
    start_sched(KEY, 1'b0);
    drain(1'b0, cyc);

    // Pseudo-random stalls
    start_sched(KEY, 1'b0);
    drain(1'b1, cyc);

    // Reset after the 5th transfer
    start_sched(KEY, 1'b0);
    sk_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(sk_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_restart", 64'(sk_valid), 64'd0);
      check("abort_no_done", 64'(done), 64'd0);
    end
    start_sched(KEY, 1'b0);
    drain(1'b0, cyc);

    // start and key_in change while busy are ignored
    start_sched(KEY, 1'b0);
    sk_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    key_in = 64'h0;
    start  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    drain(1'b0, cyc);

`ifdef DES_KS_ENC_DIR_EN
    // Encrypt order, stalled and continuous, then decrypt again
    start_sched(KEY, 1'b1);
    drain(1'b0, cyc);
    start_sched(KEY, 1'b1);
    drain(1'b1, cyc);
    start_sched(KEY, 1'b0);
    drain(1'b0, cyc);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
